// File: rtl/fetch_ir_pc_unit.sv
// Program counter, instruction register and memory data register for the multicycle CPU.
// Applies the controller's PC/IR strobes, gates the fetch on mem_ready, and keeps debug counters.
module fetch_ir_pc_unit #(
   parameter int unsigned         DATA_W   = 32,
   parameter logic [DATA_W-1:0]   PC_RESET = '0,
   parameter int unsigned         JADDR_W  = 26
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                IRWrite,
   input  logic                PCWrite,
   input  logic                PCWriteCond,
   input  logic                BEQ,
   input  logic [1:0]          PCSrc,
   input  logic                Zero,
   input  logic [DATA_W-1:0]   ALUResult,
   input  logic [DATA_W-1:0]   ALUOut,
   input  logic [DATA_W-1:0]   MemData,
   input  logic                mem_ready,
   output logic [DATA_W-1:0]   PC,
   output logic [DATA_W-1:0]   IR,
   output logic [DATA_W-1:0]   MDR,
   output logic [5:0]          OPcode,
   output logic [4:0]          rs,
   output logic [4:0]          rt,
   output logic [4:0]          rd,
   output logic [15:0]         imm16,
   output logic [JADDR_W-1:0]  jaddr,
   output logic                stall,
   output logic [31:0]         instr_count,
   output logic [31:0]         branch_taken
);

   logic [DATA_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] ir_q, ir_d;
   logic [DATA_W-1:0] mdr_q, mdr_d;
   logic [31:0]       instr_count_q, instr_count_d;
   logic [31:0]       branch_taken_q, branch_taken_d;

   logic cond;
   logic pc_en;
   logic ir_load;
   logic src_valid;

   assign stall     = IRWrite & ~mem_ready;
   assign ir_load   = IRWrite & mem_ready;
   assign cond      = BEQ ? Zero : ~Zero;
   assign pc_en     = ~stall & (PCWrite | (PCWriteCond & cond));
   assign src_valid = (PCSrc != 2'b11);

   // NOTE: every variable gets its hold value first so no path through this block infers a latch.
   always_comb begin
      pc_d           = pc_q;
      ir_d           = ir_q;
      mdr_d          = mdr_q;
      instr_count_d  = instr_count_q;
      branch_taken_d = branch_taken_q;

      if (pc_en) begin
         unique case (PCSrc)
            2'b00:   pc_d = ALUResult;
            2'b01:   pc_d = ALUOut;
            2'b10:   pc_d = {pc_q[DATA_W-1:JADDR_W], ir_q[JADDR_W-1:0]};
            default: pc_d = pc_q;
         endcase
      end

      if (ir_load) begin
         ir_d          = MemData;
         instr_count_d = instr_count_q + 32'd1;
      end

      if (mem_ready) begin
         mdr_d = MemData;
      end

      // PCWrite overrides a simultaneous conditional write, so that case is not a taken branch.
      if (PCWriteCond & cond & ~PCWrite & ~stall & src_valid) begin
         branch_taken_d = branch_taken_q + 32'd1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         pc_q           <= PC_RESET;
         ir_q           <= '0;
         mdr_q          <= '0;
         instr_count_q  <= '0;
         branch_taken_q <= '0;
      end else begin
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         mdr_q          <= mdr_d;
         instr_count_q  <= instr_count_d;
         branch_taken_q <= branch_taken_d;
      end
   end

   assign PC           = pc_q;
   assign IR           = ir_q;
   assign MDR          = mdr_q;
   assign instr_count  = instr_count_q;
   assign branch_taken = branch_taken_q;

   assign OPcode = ir_q[31:26];
   assign rs     = ir_q[25:21];
   assign rt     = ir_q[20:16];
   assign rd     = ir_q[15:11];
   assign imm16  = ir_q[15:0];
   assign jaddr  = ir_q[JADDR_W-1:0];

endmodule

// File: tb/tb_fetch_ir_pc_unit.sv
// Directed bench for fetch_ir_pc_unit: reset, fetch, stall, branches, jump, reserved source,
// counter wrap and priority, each against hand-computed values.
module tb_fetch_ir_pc_unit;

   logic        clock = 1'b0;
   logic        reset;
   logic        IRWrite, PCWrite, PCWriteCond, BEQ, Zero, mem_ready;
   logic [1:0]  PCSrc;
   logic [31:0] ALUResult, ALUOut, MemData;
   logic [31:0] PC, IR, MDR;
   logic [5:0]  OPcode;
   logic [4:0]  rs, rt, rd;
   logic [15:0] imm16;
   logic [25:0] jaddr;
   logic        stall;
   logic [31:0] instr_count, branch_taken;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   fetch_ir_pc_unit dut (
      .clock        (clock),
      .reset        (reset),
      .IRWrite      (IRWrite),
      .PCWrite      (PCWrite),
      .PCWriteCond  (PCWriteCond),
      .BEQ          (BEQ),
      .PCSrc        (PCSrc),
      .Zero         (Zero),
      .ALUResult    (ALUResult),
      .ALUOut       (ALUOut),
      .MemData      (MemData),
      .mem_ready    (mem_ready),
      .PC           (PC),
      .IR           (IR),
      .MDR          (MDR),
      .OPcode       (OPcode),
      .rs           (rs),
      .rt           (rt),
      .rd           (rd),
      .imm16        (imm16),
      .jaddr        (jaddr),
      .stall        (stall),
      .instr_count  (instr_count),
      .branch_taken (branch_taken)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one edge and settle just after it.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic idle();
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      PCSrc       = 2'b00;
   endtask

   initial begin
      reset = 1'b1; idle();
      BEQ = 1'b0; Zero = 1'b0; ALUResult = '0; ALUOut = '0;
      MemData = 32'hFFFF_FFFF; mem_ready = 1'b1;

      repeat (10) tick();
      check("rst_pc",     PC, 32'h0);
      check("rst_ir",     IR, 32'h0);
      check("rst_mdr",    MDR, 32'h0);
      check("rst_icnt",   instr_count, 32'h0);
      check("rst_bcnt",   branch_taken, 32'h0);
      check("rst_opcode", {26'd0, OPcode}, 32'h0);
      check("rst_jaddr",  {6'd0, jaddr}, 32'h0);
      check("rst_stall",  {31'd0, stall}, 32'h0);

      reset = 1'b0;
      tick();
      check("mdr_after_rst", MDR, 32'hFFFF_FFFF);
      check("ir_no_load",    IR, 32'h0);

      // Normal fetch
      IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
      ALUResult = 32'd1; MemData = 32'h0441_0005; mem_ready = 1'b1;
      #1 check("fetch_stall", {31'd0, stall}, 32'h0);
      tick(); idle();
      check("fetch_ir",     IR, 32'h0441_0005);
      check("fetch_opcode", {26'd0, OPcode}, 32'd1);
      check("fetch_rs",     {27'd0, rs}, 32'd2);
      check("fetch_rt",     {27'd0, rt}, 32'd1);
      check("fetch_rd",     {27'd0, rd}, 32'd0);
      check("fetch_imm",    {16'd0, imm16}, 32'd5);
      check("fetch_pc",     PC, 32'd1);
      check("fetch_icnt",   instr_count, 32'd1);

      // Stalled fetch: three cycles without mem_ready, then ready
      IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
      ALUResult = 32'd2; MemData = 32'h0800_0007; mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_hi", {31'd0, stall}, 32'h1);
         tick();
         check("stall_pc",  PC, 32'd1);
         check("stall_ir",  IR, 32'h0441_0005);
         check("stall_mdr", MDR, 32'h0441_0005);
      end
      mem_ready = 1'b1;
      #1 check("stall_lo", {31'd0, stall}, 32'h0);
      tick(); idle();
      check("unstall_pc",   PC, 32'd2);
      check("unstall_ir",   IR, 32'h0800_0007);
      check("unstall_mdr",  MDR, 32'h0800_0007);
      check("unstall_icnt", instr_count, 32'd2);

      // Conditional branches
      PCWriteCond = 1'b1; PCSrc = 2'b01; ALUOut = 32'h40; BEQ = 1'b1; Zero = 1'b1;
      tick();
      check("beq_taken_pc",  PC, 32'h40);
      check("beq_taken_cnt", branch_taken, 32'd1);
      ALUOut = 32'h80; Zero = 1'b0;
      tick();
      check("beq_not_pc",  PC, 32'h40);
      check("beq_not_cnt", branch_taken, 32'd1);
      BEQ = 1'b0; Zero = 1'b1;
      IRWrite = 1'b1; mem_ready = 1'b0; BEQ = 1'b1;
      tick();
      check("stall_br_pc",  PC, 32'h40);
      check("stall_br_cnt", branch_taken, 32'd1);
      IRWrite = 1'b0; mem_ready = 1'b1; BEQ = 1'b0; Zero = 1'b0;
      tick(); idle();
      check("bne_taken_pc",  PC, 32'h80);
      check("bne_taken_cnt", branch_taken, 32'd2);

      // Jump: PC=0xF0000010 and IR with jaddr=0x123 loaded in the same cycle
      IRWrite = 1'b1; PCWrite = 1'b1; PCSrc = 2'b00;
      ALUResult = 32'hF000_0010; MemData = 32'h0800_0123;
      tick(); idle();
      check("pre_jump_pc", PC, 32'hF000_0010);
      check("jaddr",       {6'd0, jaddr}, 32'h123);
      check("jump_opcode", {26'd0, OPcode}, 32'd2);
      PCWrite = 1'b1; PCSrc = 2'b10;
      tick(); idle();
      check("jump_pc", PC, 32'hF000_0123);

      // Reserved source holds PC and does not count as a taken branch
      PCWrite = 1'b1; PCSrc = 2'b11; ALUResult = 32'h55; ALUOut = 32'h66;
      tick(); idle();
      check("rsv_pc", PC, 32'hF000_0123);
      PCWriteCond = 1'b1; PCSrc = 2'b11; BEQ = 1'b1; Zero = 1'b1;
      tick(); idle();
      check("rsv_cond_pc",  PC, 32'hF000_0123);
      check("rsv_cond_cnt", branch_taken, 32'd2);

      // PCWrite and PCWriteCond together: unconditional, not counted
      PCWrite = 1'b1; PCWriteCond = 1'b1; PCSrc = 2'b00; BEQ = 1'b1; Zero = 1'b1;
      ALUResult = 32'h100;
      tick(); idle();
      check("prio_pc",  PC, 32'h100);
      check("prio_cnt", branch_taken, 32'd2);

      // Instruction counter wrap
      @(negedge clock);
      force dut.instr_count_q = 32'hFFFF_FFFF;
      #1 release dut.instr_count_q;
      check("wrap_pre", instr_count, 32'hFFFF_FFFF);
      IRWrite = 1'b1; mem_ready = 1'b1; MemData = 32'h1234_5678;
      tick(); idle();
      check("wrap_icnt", instr_count, 32'h0);
      check("wrap_ir",   IR, 32'h1234_5678);

      // Reset mid-stall discards the pending fetch
      IRWrite = 1'b1; PCWrite = 1'b1; mem_ready = 1'b0; ALUResult = 32'h200;
      reset = 1'b1;
      tick();
      check("rst_stall_pc",   PC, 32'h0);
      check("rst_stall_ir",   IR, 32'h0);
      check("rst_stall_mdr",  MDR, 32'h0);
      check("rst_stall_bcnt", branch_taken, 32'h0);
      check("rst_stall_sig",  {31'd0, stall}, 32'h1);
      idle();
      #1 check("rst_stall_clr", {31'd0, stall}, 32'h0);
      reset = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_ir_pc_unit.md
Name: fetch_ir_pc_unit

Overview:
- Holds the multicycle CPU's program counter, instruction register (IR) and memory data register (MDR).
- Executes the PC/IR control strobes issued each cycle by onestatecontroller.
- Decodes the IR into fields; its OPcode output is the controller's OPcode input, so this block sits directly upstream of and around the control FSM.
- Adds a memory-ready fetch handshake plus retired-instruction and taken-branch counters for debug.

Parameters:
DATA_W, 32, width of PC, IR, MDR, ALU buses
PC_RESET, 0, PC value loaded on reset
JADDR_W, 26, width of jump-address field IR[JADDR_W-1:0]

Ports:
clock  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
IRWrite  in  1  load IR from MemData (from controller)
PCWrite  in  1  unconditional PC write (from controller)
PCWriteCond  in  1  conditional PC write (from controller)
BEQ  in  1  1 = branch if Zero, 0 = branch if not Zero
PCSrc  in  2  PC source select
Zero  in  1  ALU zero flag
ALUResult  in  DATA_W  combinational ALU result (PC+1 in fetch)
ALUOut  in  DATA_W  registered ALU output (branch target)
MemData  in  DATA_W  memory read data
mem_ready  in  1  MemData valid this cycle
PC  out  DATA_W  current program counter
IR  out  DATA_W  instruction register
MDR  out  DATA_W  memory data register
OPcode  out  6  IR[31:26]
rs  out  5  IR[25:21]
rt  out  5  IR[20:16]
rd  out  5  IR[15:11]
imm16  out  16  IR[15:0]
jaddr  out  JADDR_W  IR[JADDR_W-1:0]
stall  out  1  fetch waiting on memory
instr_count  out  32  IR loads since reset
branch_taken  out  32  conditional writes that took effect since reset

Behaviour:
- Reset is synchronous, active-high, and takes priority over everything else.
- Reset values: PC=PC_RESET; IR=0; MDR=0; instr_count=0; branch_taken=0. stall follows its equation, so it is 0 whenever IRWrite=0.
- After reset, OPcode=0, rs=rt=rd=0, imm16=0 and jaddr=0.
- stall = IRWrite & ~mem_ready. This is combinational with no registered state.
- IR load: when IRWrite & mem_ready, IR <= MemData at the clock edge. OPcode and the other fields are pure slices of IR, so they are valid the cycle after the load.
- MDR <= MemData on every edge where mem_ready=1, independent of IRWrite. Otherwise MDR holds.
- Branch condition: cond = BEQ ? Zero : ~Zero.
- pc_en = ~stall & (PCWrite | (PCWriteCond & cond)).
- PC next-value select:
  - PCSrc=00: ALUResult
  - PCSrc=01: ALUOut
  - PCSrc=10: {PC[DATA_W-1:JADDR_W], jaddr}
  - PCSrc=11: reserved; PC holds even if pc_en.
- When pc_en=0, PC holds.
- While stall=1, both the IR load and the PC write are suppressed. The fetch PC+1 is therefore not lost: the controller holds the fetch state and the values are re-applied when mem_ready rises.
- PCWrite and PCWriteCond asserted together: treated as unconditional (PCWrite wins); branch_taken does not increment.
- branch_taken increments when PCWriteCond & cond & ~PCWrite & ~stall & PCSrc!=11.
- instr_count increments on every IR load.
- Both counters wrap modulo 2^32 (0xFFFFFFFF -> 0) with no saturation.
- Reset asserted mid-stall or mid-instruction: all state returns to reset values next edge. A pending fetch is discarded, and stall is 0 if IRWrite is also low.
- Latency: PC, IR and MDR are visible one cycle after the enabling edge. There are no combinational paths from MemData to any output; the paths from IRWrite/mem_ready to stall are the only combinational paths.

Test Plan:
- Reset behaviour: hold reset for 10 cycles with MemData=0xFFFFFFFF and mem_ready=1 -> PC=0, IR=0, MDR=0, instr_count=0, OPcode=0. Release reset -> MDR=0xFFFFFFFF next edge.
- Normal fetch: IRWrite=1, PCWrite=1, PCSrc=00, ALUResult=1, MemData=0x04410005, mem_ready=1 for one cycle -> next cycle IR=0x04410005, OPcode=1, rs=2, rt=1, imm16=5, PC=1, instr_count=1.
- Stall: same fetch with mem_ready=0 for 3 cycles, then 1 -> stall=1 for 3 cycles, PC and IR unchanged during the stall; PC=1 and IR loaded after the 4th edge; instr_count increments once.
- Conditional branch: PCWriteCond=1, PCSrc=01, ALUOut=0x40.
  - BEQ=1, Zero=1 -> PC=0x40, branch_taken=1.
  - BEQ=1, Zero=0 -> PC unchanged.
  - BEQ=0, Zero=0 -> PC=0x40, branch_taken=2.
- Jump and reserved source:
  - PC=0xF0000010, IR jaddr=0x0000123, PCWrite=1, PCSrc=10 -> PC=0xF0000123.
  - PCSrc=11 with PCWrite=1 -> PC unchanged.
- Wrap and priority:
  - Force instr_count to 0xFFFFFFFF and do one fetch -> instr_count=0.
  - PCWrite=1 and PCWriteCond=1 with cond true -> PC updates, branch_taken unchanged.
